// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: actuated two-approach NS/EW phase sequencer with yellow and all-red clearance.
// Optional pedestrian walk phase is built when TRAFFIC_PED_WALK_EN is defined.
module intersection_phase_scheduler #(
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int WALK_TIME   = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] G_MIN  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] W_END  = CNT_W'(WALK_TIME - 1);

    state_t           state, next;
    logic [CNT_W-1:0] timer;
    logic             ns_pend, ew_pend, go_ped, enter;

    assign enter = next != state;

`ifdef TRAFFIC_PED_WALK_EN
    // prev_dir remembers which green the walk interrupted: 1 = EW follows, 0 = NS follows
    logic ped_pend, prev_dir;
    assign go_ped = ped_pend;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_pend <= 1'b0;
            prev_dir <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= (enter && next == PED_WALK) ? 1'b0 : ped_pend | ped_req;
            if (enter && next == PED_WALK) prev_dir <= state == ALLRED_A;
            walk <= next == PED_WALK;
        end
    end
`else
    logic unused_ped;
    assign go_ped     = 1'b0;
    assign walk       = 1'b0;
    assign unused_ped = ^{ped_req, W_END};
`endif

    always_comb begin
        next = state;
        case (state)
            NS_GREEN:  if ((timer >= G_MIN && ew_pend) || timer == G_MAX) next = NS_YELLOW;
            NS_YELLOW: if (timer == Y_END) next = ALLRED_A;
            ALLRED_A:  if (timer == AR_END) next = go_ped ? PED_WALK : EW_GREEN;
            EW_GREEN:  if ((timer >= G_MIN && ns_pend) || timer == G_MAX) next = EW_YELLOW;
            EW_YELLOW: if (timer == Y_END) next = ALLRED_B;
            ALLRED_B:  if (timer == AR_END) next = go_ped ? PED_WALK : NS_GREEN;
`ifdef TRAFFIC_PED_WALK_EN
            PED_WALK:  if (timer == W_END) next = prev_dir ? EW_GREEN : NS_GREEN;
`endif
            default:   next = ALLRED_B;
        endcase
    end

    // lamps and phase are registered from next so they all move on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ALLRED_B;
            timer     <= '0;
            ns_pend   <= 1'b0;
            ew_pend   <= 1'b0;
            ns_red    <= 1'b1;
            ns_yellow <= 1'b0;
            ns_green  <= 1'b0;
            ew_red    <= 1'b1;
            ew_yellow <= 1'b0;
            ew_green  <= 1'b0;
            phase     <= 3'd5;
        end else begin
            state     <= next;
            timer     <= enter ? '0 : timer + {{(CNT_W-1){1'b0}}, ~&timer};
            ns_pend   <= (enter && next == NS_GREEN) ? 1'b0 : ns_pend | ns_req;
            ew_pend   <= (enter && next == EW_GREEN) ? 1'b0 : ew_pend | ew_req;
            ns_green  <= next == NS_GREEN;
            ns_yellow <= next == NS_YELLOW;
            ns_red    <= next != NS_GREEN && next != NS_YELLOW;
            ew_green  <= next == EW_GREEN;
            ew_yellow <= next == EW_YELLOW;
            ew_red    <= next != EW_GREEN && next != EW_YELLOW;
            phase     <= next;
        end
    end
endmodule
